puf_eval_ctrl: RTL and testbench
================================

Name: puf_eval_ctrl

Overview:
- Clocked controller that sits directly downstream of the one-bit PUF cell and also drives its enable and reset.
- On request it runs N_EVAL evaluations: reset the PUF, enable it, wait a settle window, then sample its output through a 2-flop synchronizer.
- Majority-votes the samples into one response bit and reports a stability flag and a ones count.
- The result is presented to the chip-level wrapper with a single-cycle valid pulse.

Parameters:
- N_EVAL, 15, number of evaluations per request; must be odd, range 1..255.
- RST_CYCLES, 2, cycles puf_reset is held high per evaluation; minimum 1.
- SETTLE_CYCLES, 16, cycles puf_start is held high before sampling; minimum 3, which covers synchronizer latency.
- CNT_W, 8, width of internal cycle/evaluation counters and of ones_count.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start_req  input  1  single-cycle request to begin an evaluation run; sampled on rising clk.
- puf_out  input  1  raw asynchronous output of the PUF cell (its OUT).
- puf_start  output  1  drives PUF START (latch enable).
- puf_reset  output  1  drives PUF reset; active-high, matching the cell.
- busy  output  1  high from the cycle after an accepted start_req until resp_valid.
- resp_valid  output  1  one-cycle pulse when results are ready.
- resp_bit  output  1  majority result; held until the next resp_valid.
- stable  output  1  1 when all N_EVAL samples agreed; held with resp_bit.
- ones_count  output  CNT_W  number of samples equal to 1; held with resp_bit.

Behaviour:
- Reset: all outputs are 0 while rst_n=0, except puf_reset, which is 1 so the PUF is cleared. Also clears state to IDLE, all counters, and both synchronizer flops.
- Synchronizer: puf_out passes through two flops (sync1, sync2). Only sync2 is ever used.
- States and transitions:
  - IDLE: puf_start=0, puf_reset=0, busy=0. On start_req=1, clear the evaluation counter and the ones accumulator, then go to PRST.
  - PRST: puf_reset=1, puf_start=0, for exactly RST_CYCLES cycles, then go to ENBL.
  - ENBL: puf_reset=0, puf_start=1, for exactly SETTLE_CYCLES cycles.
    - On the last ENBL cycle, sync2 is captured: the accumulator increments if sync2=1, and the evaluation counter increments.
    - If the evaluation counter has then reached N_EVAL, go to DONE; otherwise go to PRST.
  - DONE: puf_start=0, puf_reset=0, for one cycle. Outputs update and resp_valid=1 for this cycle only. Next state is IDLE.
- Result rules, registered in DONE:
  - resp_bit = (ones > N_EVAL/2), using integer division.
  - stable = (ones==0) or (ones==N_EVAL).
  - ones_count = ones.
- Latency: start_req accepted at cycle T gives resp_valid at cycle T+1+N_EVAL*(RST_CYCLES+SETTLE_CYCLES). Default is T+271.
- busy: 1 in PRST and ENBL; drops to 0 in the DONE cycle, concurrent with resp_valid.
- start_req while busy or in DONE is ignored, with no queuing.
- start_req in the IDLE cycle immediately after DONE is accepted normally.
- Held outputs: resp_bit, stable and ones_count hold their last values through the next run and change only at its DONE. The accumulator is internal and is not visible mid-run.
- Async reset mid-run:
  - Aborts immediately to IDLE; outputs return to their reset values.
  - puf_reset goes to 1 asynchronously and returns to 0 on the first clock edge after rst_n deasserts.
  - No resp_valid is produced for the aborted run.
- puf_out changing during PRST or before the last ENBL cycle has no effect on the result.
- Counter widths: ones and the evaluation counter saturate-free. CNT_W must satisfy 2^CNT_W > N_EVAL; this is checked by an elaboration-time assertion.

Test Plan:
- Reset check: hold rst_n=0 for 5 cycles → puf_reset=1, puf_start=0, busy=0, resp_valid=0, ones_count=0.
- Constant-one response: puf_out tied to 1, pulse start_req → resp_valid exactly 271 cycles later, resp_bit=1, stable=1, ones_count=15. puf_start toggles 15 times with 16-cycle high windows, and puf_reset shows 2-cycle pulses between them.
- Majority with noise: model drives puf_out=1 for evaluations 0-7 and 0 for 8-14 → ones_count=8, resp_bit=1, stable=0. Swap to 7 ones → ones_count=7, resp_bit=0, stable=0.
- Request handling: start_req reasserted at cycles 10 and 200 of a run is ignored, with a single resp_valid. A start_req in the cycle right after DONE starts a second run whose resp_valid arrives 271 cycles later. Previous resp_bit, stable and ones_count stay held until then.
- Reset mid-run: assert rst_n=0 at cycle 100 of a run → state goes to IDLE, puf_reset=1 immediately, and no resp_valid appears. A fresh start_req after release yields a correct full run.
- Synchronizer timing: puf_out toggles from 0 to 1 exactly 1 cycle before the last ENBL cycle → that sample counts as 0. Toggling 2 or more cycles before → counts as 1.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation controller: sequences reset/enable of a one-bit PUF cell,
// samples its output through a 2-flop synchronizer N_EVAL times, and reports
// a majority-voted response bit, a stability flag and the ones count.
module puf_eval_ctrl #(
  parameter int unsigned N_EVAL        = 15,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_req,
  input  logic             puf_out,
  output logic             puf_start,
  output logic             puf_reset,
  output logic             busy,
  output logic             resp_valid,
  output logic             resp_bit,
  output logic             stable,
  output logic [CNT_W-1:0] ones_count
);

  if ((N_EVAL % 2) == 0 || N_EVAL < 1 || N_EVAL > 255) begin : g_bad_neval
    $error("puf_eval_ctrl: N_EVAL must be odd and in 1..255");
  end
  if ((2 ** CNT_W) <= N_EVAL) begin : g_bad_cntw
    $error("puf_eval_ctrl: CNT_W too narrow for N_EVAL");
  end
  if (RST_CYCLES < 1 || SETTLE_CYCLES < 3 ||
      RST_CYCLES > (2 ** CNT_W) || SETTLE_CYCLES > (2 ** CNT_W)) begin : g_bad_cyc
    $error("puf_eval_ctrl: RST_CYCLES/SETTLE_CYCLES out of range");
  end

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] NEVAL_C     = CNT_W'(N_EVAL);
  localparam logic [CNT_W-1:0] HALF_C      = CNT_W'(N_EVAL / 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRST = 2'd1,
    S_ENBL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] eval_q, eval_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             sync1_q, sync2_q;
  logic             resp_bit_q, resp_bit_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] ones_count_q, ones_count_d;
  logic             puf_start_q, puf_reset_q, busy_q, resp_valid_q;

  // Two-flop synchronizer for the asynchronous PUF output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= puf_out;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counters, accumulator and result computation.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    eval_d       = eval_q;
    ones_d       = ones_q;
    resp_bit_d   = resp_bit_q;
    stable_d     = stable_q;
    ones_count_d = ones_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          cyc_d   = '0;
          eval_d  = '0;
          ones_d  = '0;
          state_d = S_PRST;
        end
      end
      S_PRST: begin
        if (cyc_q == RST_LAST) begin
          cyc_d   = '0;
          state_d = S_ENBL;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_ENBL: begin
        if (cyc_q == SETTLE_LAST) begin
          cyc_d  = '0;
          ones_d = ones_q + CNT_W'(sync2_q);
          eval_d = eval_q + 1'b1;
          if (eval_d == NEVAL_C) begin
            // Results are loaded on entry to DONE so they are visible
            // in the same cycle as the resp_valid pulse.
            state_d      = S_DONE;
            resp_bit_d   = (ones_d > HALF_C);
            stable_d     = (ones_d == '0) || (ones_d == NEVAL_C);
            ones_count_d = ones_d;
          end else begin
            state_d = S_PRST;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and results; strobes are registered from the next state
  // so puf_reset can carry its own asserted-in-reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      resp_bit_q   <= 1'b0;
      stable_q     <= 1'b0;
      ones_count_q <= '0;
      puf_start_q  <= 1'b0;
      puf_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      eval_q       <= eval_d;
      ones_q       <= ones_d;
      resp_bit_q   <= resp_bit_d;
      stable_q     <= stable_d;
      ones_count_q <= ones_count_d;
      puf_start_q  <= (state_d == S_ENBL);
      puf_reset_q  <= (state_d == S_PRST);
      busy_q       <= (state_d == S_PRST) || (state_d == S_ENBL);
      resp_valid_q <= (state_d == S_DONE);
    end
  end

  assign puf_start  = puf_start_q;
  assign puf_reset  = puf_reset_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_bit   = resp_bit_q;
  assign stable     = stable_q;
  assign ones_count = ones_count_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: directed and randomized PUF output
// patterns checked against a per-cycle timing model and a majority-vote model.
module tb_puf_eval_ctrl;

  localparam int N   = 15;
  localparam int R   = 2;
  localparam int S   = 16;
  localparam int W   = 8;
  localparam int P   = R + S;
  localparam int LAT = 1 + N * P;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_req;
  logic         puf_out;
  logic         puf_start;
  logic         puf_reset;
  logic         busy;
  logic         resp_valid;
  logic         resp_bit;
  logic         stable;
  logic [W-1:0] ones_count;

  int checks = 0;
  int errors = 0;

  // puf_out value driven during cycle T+k of a run accepted in cycle T
  logic pv [0:LAT];

  logic         exp_bit;
  logic         exp_stable;
  logic [W-1:0] exp_ones;

  puf_eval_ctrl #(
    .N_EVAL       (N),
    .RST_CYCLES   (R),
    .SETTLE_CYCLES(S),
    .CNT_W        (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_req (start_req),
    .puf_out   (puf_out),
    .puf_start (puf_start),
    .puf_reset (puf_reset),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_bit  (resp_bit),
    .stable    (stable),
    .ones_count(ones_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is in the IDLE cycle T (just after an edge). Runs a full
  // request with puf_out taken from pv[], optionally re-pulsing start_req
  // at offsets x1/x2, and checks every cycle up to and including DONE.
  task automatic do_run(input int x1, input int x2);
    int   ones;
    int   ph;
    logic mbit;
    logic mst;
    ones = 0;
    // Sample of evaluation e is what sync2 holds in its last settle cycle,
    // i.e. puf_out as driven two cycles earlier.
    for (int e = 0; e < N; e++) ones += int'(pv[(e + 1) * P - 2]);
    mbit = (ones > N / 2);
    mst  = (ones == 0) || (ones == N);
    start_req = 1'b1;
    puf_out   = pv[0];
    for (int k = 1; k <= LAT; k++) begin
      step();
      start_req = (k == x1) || (k == x2);
      puf_out   = pv[k];
      @(negedge clk);
      if (k < LAT) begin
        ph = (k - 1) % P;
        chk("busy_run",       32'(busy),       32'(1));
        chk("resp_valid_run", 32'(resp_valid), 32'(0));
        chk("puf_reset_run",  32'(puf_reset),  32'(ph < R));
        chk("puf_start_run",  32'(puf_start),  32'(ph >= R));
        chk("held_bit",       32'(resp_bit),   32'(exp_bit));
        chk("held_stable",    32'(stable),     32'(exp_stable));
        chk("held_ones",      32'(ones_count), 32'(exp_ones));
      end else begin
        chk("resp_valid_done", 32'(resp_valid), 32'(1));
        chk("busy_done",       32'(busy),       32'(0));
        chk("puf_start_done",  32'(puf_start),  32'(0));
        chk("puf_reset_done",  32'(puf_reset),  32'(0));
        chk("resp_bit",        32'(resp_bit),   32'(mbit));
        chk("stable",          32'(stable),     32'(mst));
        chk("ones_count",      32'(ones_count), 32'(ones));
      end
    end
    exp_bit    = mbit;
    exp_stable = mst;
    exp_ones   = W'(ones);
  endtask

  // One IDLE cycle after DONE: pulse must be gone, controller idle.
  task automatic idle_gap();
    step();
    @(negedge clk);
    chk("idle_valid", 32'(resp_valid), 32'(0));
    chk("idle_busy",  32'(busy),       32'(0));
    chk("idle_reset", 32'(puf_reset),  32'(0));
    chk("idle_start", 32'(puf_start),  32'(0));
    step();
  endtask

  initial begin
    int bias;
    int vcount;
    rst_n      = 1'b0;
    start_req  = 1'b0;
    puf_out    = 1'b0;
    exp_bit    = 1'b0;
    exp_stable = 1'b0;
    exp_ones   = '0;

    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_puf_reset",  32'(puf_reset),  32'(1));
    chk("rst_puf_start",  32'(puf_start),  32'(0));
    chk("rst_busy",       32'(busy),       32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_ones",       32'(ones_count), 32'(0));
    chk("rst_bit",        32'(resp_bit),   32'(0));
    chk("rst_stable",     32'(stable),     32'(0));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_puf_reset_hold", 32'(puf_reset), 32'(1));
    step();
    @(negedge clk);
    chk("rel_puf_reset_clr", 32'(puf_reset), 32'(0));
    step();

    // Constant-one response
    for (int k = 0; k <= LAT; k++) pv[k] = 1'b1;
    do_run(-1, -1);
    chk("const1_ones",   32'(ones_count), 32'(15));
    chk("const1_bit",    32'(resp_bit),   32'(1));
    chk("const1_stable", 32'(stable),     32'(1));
    idle_gap();

    // Majority: evaluations 0-7 one, 8-14 zero
    pv[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) pv[k] = (((k - 1) / P) < 8);
    do_run(-1, -1);
    chk("maj8_ones",   32'(ones_count), 32'(8));
    chk("maj8_bit",    32'(resp_bit),   32'(1));
    chk("maj8_stable", 32'(stable),     32'(0));

    // Back-to-back start right after DONE, with ignored mid-run requests;
    // seven ones this time
    step();
    for (int k = 1; k <= LAT; k++) pv[k] = (((k - 1) / P) < 7);
    do_run(10, 200);
    chk("maj7_ones",   32'(ones_count), 32'(7));
    chk("maj7_bit",    32'(resp_bit),   32'(0));
    chk("maj7_stable", 32'(stable),     32'(0));
    idle_gap();

    // All zero
    for (int k = 0; k <= LAT; k++) pv[k] = 1'b0;
    do_run(-1, -1);
    chk("zero_stable", 32'(stable), 32'(1));
    idle_gap();

    // Synchronizer: rise one cycle before last settle cycle is too late
    for (int k = 0; k <= LAT; k++) pv[k] = 1'b0;
    pv[P - 1] = 1'b1;
    pv[P]     = 1'b1;
    do_run(-1, -1);
    chk("sync_late_ones", 32'(ones_count), 32'(0));
    idle_gap();

    // Rise two cycles before is captured
    pv[P - 2] = 1'b1;
    do_run(-1, -1);
    chk("sync_early_ones", 32'(ones_count), 32'(1));
    idle_gap();

    // Randomized noise at random bias
    for (int r = 0; r < 4; r++) begin
      bias = $urandom_range(0, 100);
      for (int k = 0; k <= LAT; k++) pv[k] = ($urandom_range(0, 99) < bias);
      do_run(-1, -1);
      idle_gap();
    end

    // Reset mid-run
    for (int k = 0; k <= LAT; k++) pv[k] = $urandom_range(0, 1) == 1;
    start_req = 1'b1;
    puf_out   = pv[0];
    for (int k = 1; k <= 100; k++) begin
      step();
      start_req = 1'b0;
      puf_out   = pv[k];
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_puf_reset",  32'(puf_reset),  32'(1));
    chk("abort_puf_start",  32'(puf_start),  32'(0));
    chk("abort_busy",       32'(busy),       32'(0));
    chk("abort_resp_valid", 32'(resp_valid), 32'(0));
    chk("abort_ones",       32'(ones_count), 32'(0));
    chk("abort_bit",        32'(resp_bit),   32'(0));
    chk("abort_stable",     32'(stable),     32'(0));
    exp_bit    = 1'b0;
    exp_stable = 1'b0;
    exp_ones   = '0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_reset_hold", 32'(puf_reset), 32'(1));
    vcount = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) vcount++;
    end
    chk("abort_no_activity", 32'(vcount),    32'(0));
    chk("abort_reset_clr",   32'(puf_reset), 32'(0));
    step();
    for (int k = 0; k <= LAT; k++) pv[k] = $urandom_range(0, 3) != 0;
    do_run(-1, -1);
    idle_gap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
